// File: rtl/dr_onehot_capture_pkg.sv
// dr_pkg: shared state type, sizes and one-hot helpers for the dual-rail capture stage
package dr_pkg;
   localparam int N_OUT = 16;
   localparam int IDX_W = 4;
   localparam int TMO   = 15;
   localparam int ERR_W = 8;
   typedef enum logic [1:0] {IDLE, PRECHARGE, EVAL, HOLD} state_t;
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_OUT-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int k = 0; k < N_OUT; k++) if (v[k]) r |= IDX_W'(k);
      return r;
   endfunction
   // clearing the lowest set bit leaves zero only for a single set bit
   function automatic logic popcount_is_one(input logic [N_OUT-1:0] v);
      return (v != '0) && ((v & (v - N_OUT'(1))) == '0);
   endfunction
endpackage

// File: rtl/dr_onehot_capture_if.sv
// dr_onehot_capture_if: decoder rails, control and output handshake of the capture stage
// slave = capture block (drives pre/out_valid/idx/err/err_cnt/busy), master = its environment
interface dr_onehot_capture_if;
   import dr_pkg::*;
   logic             start;
   logic             out_ready;
   logic [N_OUT-1:0] y_t;
   logic [N_OUT-1:0] y_f;
   logic             pre;
   logic             out_valid;
   logic [IDX_W-1:0] idx_t;
   logic [IDX_W-1:0] idx_f;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             busy;
   modport master (output start, out_ready, y_t, y_f,
                   input  pre, out_valid, idx_t, idx_f, err, err_cnt, busy);
   modport slave  (input  start, out_ready, y_t, y_f,
                   output pre, out_valid, idx_t, idx_f, err, err_cnt, busy);
endinterface

// File: rtl/dr_completion_detect.sv
// dr_completion_detect: combinational spacer/completion/clash/one-hot detection and index encode
// in: i_y_t/i_y_f rails; out: o_spacer, o_complete, o_clash, o_onehot_ok, o_idx
module dr_completion_detect #(
   parameter int N_OUT = dr_pkg::N_OUT,
   parameter int IDX_W = $clog2(N_OUT)
) (
   input  logic [N_OUT-1:0] i_y_t,
   input  logic [N_OUT-1:0] i_y_f,
   output logic             o_spacer,
   output logic             o_complete,
   output logic             o_clash,
   output logic             o_onehot_ok,
   output logic [IDX_W-1:0] o_idx
);
   localparam int PW = dr_pkg::N_OUT;
   // narrower instances zero-extend into the package helpers' width
   logic [PW-1:0] w_ext;
   assign w_ext       = PW'(i_y_t);
   assign o_spacer    = (i_y_t == '0) && (i_y_f == '0);
   assign o_complete  = &(i_y_t ^ i_y_f);
   assign o_clash     = |(i_y_t & i_y_f);
   assign o_onehot_ok = dr_pkg::popcount_is_one(w_ext);
   assign o_idx       = IDX_W'(dr_pkg::onehot_to_idx(w_ext));
endmodule

// File: rtl/dr_onehot_capture.sv
// dr_onehot_capture: sequences decoder precharge/eval, captures a one-hot result as a dual-rail index
// in: clk, rst (async, active-high), bus.slave (start, y_t/y_f, out_ready)
// out: bus.slave (pre, out_valid, idx_t/idx_f, err, err_cnt, busy), all registered
module dr_onehot_capture
   import dr_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   dr_onehot_capture_if.slave bus
);
   localparam int TW = $clog2(TMO + 1);
   state_t           r_state, w_state_n;
   logic [TW-1:0]    r_timer, w_timer_n;
   logic             r_pre, r_valid, r_err, r_busy;
   logic [IDX_W-1:0] r_idx_t, r_idx_f;
   logic [ERR_W-1:0] r_err_cnt;
   logic             w_spacer, w_complete, w_clash, w_onehot_ok, w_tmo;
   logic             w_err_n, w_load, w_clear;
   logic [IDX_W-1:0] w_idx;
   dr_completion_detect #(.N_OUT(N_OUT), .IDX_W(IDX_W)) u_cd (
      .i_y_t(bus.y_t), .i_y_f(bus.y_f), .o_spacer(w_spacer), .o_complete(w_complete),
      .o_clash(w_clash), .o_onehot_ok(w_onehot_ok), .o_idx(w_idx)
   );
   assign w_tmo = r_timer == TW'(TMO);
   always_comb begin
      w_state_n = r_state;
      w_err_n   = 1'b0;
      w_load    = 1'b0;
      w_clear   = 1'b0;
      case (r_state)
         IDLE:      if (bus.start) w_state_n = PRECHARGE;
         PRECHARGE: if (w_spacer) w_state_n = EVAL;
                    else if (w_tmo) begin
                       w_err_n   = 1'b1;
                       w_state_n = IDLE;
                    end
         EVAL:      if (w_clash || (w_complete && !w_onehot_ok) || (!w_complete && w_tmo)) begin
                       w_err_n   = 1'b1;
                       w_state_n = IDLE;
                    end else if (w_complete) begin
                       w_load    = 1'b1;
                       w_state_n = HOLD;
                    end
         // out_valid is always set in HOLD, so out_ready alone completes the handshake
         HOLD:      if (bus.out_ready) begin
                       w_clear   = 1'b1;
                       w_state_n = bus.start ? PRECHARGE : IDLE;
                    end
         default:   w_state_n = IDLE;
      endcase
      w_timer_n = (w_state_n == r_state && (r_state == PRECHARGE || r_state == EVAL)) ?
                  r_timer + TW'(1) : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_pre     <= 1'b1;
         r_valid   <= 1'b0;
         r_idx_t   <= '0;
         r_idx_f   <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_timer   <= w_timer_n;
         r_pre     <= w_state_n != EVAL;
         r_busy    <= w_state_n != IDLE;
         r_err     <= w_err_n;
         r_err_cnt <= (w_err_n && r_err_cnt != '1) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
         r_valid   <= w_load ? 1'b1 : (w_clear ? 1'b0 : r_valid);
         r_idx_t   <= w_load ? w_idx : (w_clear ? '0 : r_idx_t);
         r_idx_f   <= w_load ? ~w_idx : (w_clear ? '0 : r_idx_f);
      end
   end
   assign bus.pre       = r_pre;
   assign bus.out_valid = r_valid;
   assign bus.idx_t     = r_idx_t;
   assign bus.idx_f     = r_idx_f;
   assign bus.err       = r_err;
   assign bus.err_cnt   = r_err_cnt;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dr_onehot_capture.sv
// tb_dr_onehot_capture: directed and random captures against a transaction-level decoder model
module tb_dr_onehot_capture;
   import dr_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pre_t = '0, pre_f = '0, ev_t = '0, ev_f = '0;
   int          total = 0, bad = 0, exp_cnt = 0;
   dr_onehot_capture_if bus ();
   // decoder model: rails follow pre combinationally (spacer-phase values vs evaluated values)
   assign bus.y_t = bus.pre ? pre_t : ev_t;
   assign bus.y_f = bus.pre ? pre_f : ev_f;
   dr_onehot_capture dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // 0 = one-hot capture, 1 = immediate error, 2 = eval timeout
   function automatic int classify(input logic [15:0] t, input logic [15:0] f, output int idx);
      idx = 0;
      if ((t & f) != 16'h0) return 1;
      if ((t ^ f) != 16'hFFFF) return 2;
      if ($countones(t) != 1) return 1;
      for (int k = 0; k < 16; k++) if (t == (16'h1 << k)) idx = k;
      return 0;
   endfunction
   task automatic run(input logic [15:0] t, input logic [15:0] f);
      int kind, idx, n;
      kind = classify(t, f, idx);
      ev_t = t;
      ev_f = f;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      chk("pc_busy", bus.busy, 1);
      chk("pc_pre", bus.pre, 1);
      tick;
      chk("ev_pre", bus.pre, 0);
      n = 0;
      if (kind == 2) begin
         while (!bus.err && n < 40) begin
            tick;
            n++;
         end
         chk("ev_tmo_cycles", n, TMO + 1);
      end else tick;
      if (kind == 0) begin
         chk("cap_valid", bus.out_valid, 1);
         chk("cap_idx_t", bus.idx_t, idx);
         chk("cap_idx_f", bus.idx_f, 15 - idx);
         chk("cap_err", bus.err, 0);
         chk("cap_pre", bus.pre, 1);
         bus.out_ready = 1'b1;
         tick;
         bus.out_ready = 1'b0;
         chk("hs_valid", bus.out_valid, 0);
         chk("hs_idx_t", bus.idx_t, 0);
         chk("hs_idx_f", bus.idx_f, 0);
         chk("hs_busy", bus.busy, 0);
      end else begin
         exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
         chk("err_pulse", bus.err, 1);
         chk("err_cnt", bus.err_cnt, exp_cnt);
         chk("err_valid", bus.out_valid, 0);
         chk("err_idx_t", bus.idx_t, 0);
         chk("err_busy", bus.busy, 0);
         tick;
         chk("err_single", bus.err, 0);
      end
   endtask
   initial begin
      int n, k, j;
      logic [15:0] t, f;
      int seq[2] = '{15, 5};
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pre", bus.pre, 1);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_idx_t", bus.idx_t, 0);
      chk("rst_idx_f", bus.idx_f, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_cnt", bus.err_cnt, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      run(16'h0200, 16'hFDFF);
      run(16'h0201, 16'hFDFE);
      run(16'h0001, 16'h0001);
      pre_t = 16'h0001;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      n = 0;
      while (!bus.err && n < 40) begin
         tick;
         n++;
      end
      exp_cnt++;
      chk("pc_tmo_cycles", n, TMO + 1);
      chk("pc_tmo_cnt", bus.err_cnt, exp_cnt);
      chk("pc_tmo_busy", bus.busy, 0);
      pre_t = '0;
      tick;
      ev_t = 16'h0001;
      ev_f = 16'hFFFE;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      chk("b2b_idx0", bus.idx_t, 0);
      chk("b2b_valid0", bus.out_valid, 1);
      foreach (seq[i]) begin
         ev_t = 16'h1 << seq[i];
         ev_f = ~ev_t;
         bus.out_ready = 1'b1;
         bus.start = 1'b1;
         tick;
         bus.out_ready = 1'b0;
         bus.start = 1'b0;
         chk("b2b_pc_busy", bus.busy, 1);
         chk("b2b_pc_valid", bus.out_valid, 0);
         chk("b2b_pc_pre", bus.pre, 1);
         tick;
         chk("b2b_ev_pre", bus.pre, 0);
         tick;
         chk("b2b_valid", bus.out_valid, 1);
         chk("b2b_idx_t", bus.idx_t, seq[i]);
         chk("b2b_idx_f", bus.idx_f, 15 - seq[i]);
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      chk("b2b_end_busy", bus.busy, 0);
      ev_t = 16'h0080;
      ev_f = 16'hFF7F;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      for (int i = 0; i < 10; i++) begin
         bus.start = i[0];
         tick;
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_idx_t", bus.idx_t, 7);
         chk("bp_idx_f", bus.idx_f, 8);
         chk("bp_pre", bus.pre, 1);
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      chk("bp_release_busy", bus.busy, 0);
      tick;
      chk("bp_not_queued", bus.busy, 0);
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 15);
         j = (k + 1 + $urandom_range(0, 14)) % 16;
         case ($urandom_range(0, 3))
            0: begin t = 16'h1 << k; f = ~t; end
            1: begin t = (16'h1 << k) | (16'h1 << j); f = ~t; end
            2: begin t = 16'($urandom) | (16'h1 << k); f = 16'($urandom) | (16'h1 << k); end
            default: begin t = 16'h1 << k; f = ~t & ~(16'h1 << j); end
         endcase
         run(t, f);
      end
      ev_t = 16'h0001;
      ev_f = 16'h0000;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      chk("rst_mid_eval", bus.pre, 0);
      #2 rst = 1'b1;
      #1;
      exp_cnt = 0;
      chk("arst_pre", bus.pre, 1);
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_idx_t", bus.idx_t, 0);
      chk("arst_idx_f", bus.idx_f, 0);
      chk("arst_cnt", bus.err_cnt, 0);
      chk("arst_busy", bus.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      for (int i = 0; i < 300; i++) run(16'h0001, 16'h0001);
      chk("sat_cnt", bus.err_cnt, 255);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dr_onehot_capture.md
Name: dr_onehot_capture

Overview:
- Dual-rail capture and encode stage directly downstream of the 4x4 cross decoder (CD4_0).
- Sequences the decoder through precharge (spacer) and evaluate phases.
- Waits for dual-rail completion on the 16 true/false output pairs, checks the one-hot property, then registers a dual-rail 4-bit index.
- Presents the index to the consumer with a valid/ready handshake and counts protocol errors.

Parameters:
- N_OUT, 16, number of decoder output pairs (y/ybar).
- IDX_W, 4, encoded index width; equals log2(N_OUT).
- TMO, 15, maximum cycles spent in PRECHARGE or EVAL before timeout.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request one capture; sampled only in IDLE, or in HOLD on the handshake cycle.
- y_t  in  N_OUT  true rails from the decoder (y).
- y_f  in  N_OUT  false rails from the decoder (ybar).
- pre  out  1  precharge request; 1 forces the decoder inputs to spacer (all rails 0).
- out_valid  out  1  index valid.
- out_ready  in  1  consumer ready.
- idx_t  out  IDX_W  true rail of the encoded index.
- idx_f  out  IDX_W  false rail of the encoded index.
- err  out  1  single-cycle error pulse.
- err_cnt  out  ERR_W  saturating error count.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Registered outputs; reset values: pre=1, out_valid=0, idx_t=0, idx_f=0 (spacer), err=0, err_cnt=0, busy=0, state=IDLE, timer=0.
- y_t and y_f are combinational from decoder inputs gated by pre, all in the clk domain. No synchronisers.
- Helper signals:
  - spacer = (y_t==0 && y_f==0).
  - complete = ((y_t ^ y_f) == all-ones).
  - clash = |(y_t & y_f).
- Timer resets to 0 on every state entry and increments each cycle in PRECHARGE and EVAL.
- FSM:
  - IDLE: pre=1. On start, go to PRECHARGE.
  - PRECHARGE: pre=1.
    - If spacer, go to EVAL.
    - Else if timer==TMO, raise error and go to IDLE.
  - EVAL: pre=0. Checks in priority order:
    - clash: error, go to IDLE.
    - complete && popcount(y_t)==1: idx_t=binary index of the set bit, idx_f=~idx_t, out_valid=1, go to HOLD.
    - complete && popcount!=1: error, go to IDLE.
    - timer==TMO: error, go to IDLE.
    - otherwise stay in EVAL.
  - HOLD: pre=1 (decoder returns to spacer while output is held). out_valid, idx_t and idx_f stay stable.
    - On out_valid && out_ready: out_valid=0, idx_t=idx_f=0. Next state is PRECHARGE if start is high in the same cycle, else IDLE.
- Error: err=1 for exactly one cycle; err_cnt increments and saturates at 2^ERR_W-1; idx_t and idx_f stay 0.
- start outside IDLE and the HOLD handshake cycle is ignored, not queued.
- Latency: start in cycle 0 gives PRECHARGE in cycle 1. If spacer is seen in cycle 1, the block is in EVAL in cycle 2 (pre=0). If complete in cycle 2, out_valid=1 in cycle 3. Minimum start-to-valid is 3 cycles.
- Back-to-back throughput: one capture per 3 cycles (handshake-with-start, PRECHARGE, EVAL).
- Asserting rst mid-operation immediately returns every output to its reset value, including err_cnt=0 and pre=1, so the decoder is forced to spacer.
- Index encoding is bit position: y_t bit k set gives idx_t=k.

Decomposition:
- Package dr_pkg holds:
  - state enum {IDLE, PRECHARGE, EVAL, HOLD};
  - N_OUT and IDX_W constants;
  - function onehot_to_idx;
  - function popcount_is_one.
- One sub-module, dr_completion_detect: purely combinational. Takes y_t/y_f; produces spacer, complete, clash, onehot_ok and the encoded idx. It is reusable on the 4-wide CD2 outputs by setting N_OUT=4.

Test Plan:
- Nominal: start=1. Decoder model gives spacer in PRECHARGE, then y_t=16'h0200 and y_f=16'hFDFF in EVAL. Required: out_valid in cycle 3, idx_t=4'h9, idx_f=4'h6; cleared the cycle after out_ready.
- Non-one-hot: in EVAL drive y_t=16'h0201, y_f=16'hFDFE. Required: err pulse for 1 cycle, err_cnt=1, return to IDLE, out_valid stays 0.
- Clash and timeout:
  - y_t=y_f=16'h0001 in EVAL: error.
  - Separately, hold y_t=16'h0001 with y_f=0 during PRECHARGE: timeout after 15 cycles, error, err_cnt increments.
- Back-to-back: out_ready=1 and start=1 held in HOLD. Required: next capture reaches PRECHARGE with no IDLE cycle; 3-cycle throughput; idx follows the sequence 0, 15, 5.
- Backpressure: out_ready=0 for 10 cycles in HOLD, with start pulses during that time. Required: idx stable, pre=1, start ignored.
- Reset: assert rst during EVAL. Required: immediately pre=1, out_valid=0, idx_t=idx_f=0, err_cnt=0, busy=0. Separately, 300 forced errors: err_cnt saturates at 255.
